// File: rtl/branch_unit.sv
// branch_unit: sequences BR/JMP/JSR/JSRR through BEN load, wait, evaluate and execute steps
module branch_unit #(
  parameter int BEN_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] IR,
  input  logic [15:0] PC_IN,
  input  logic        BEN_IN,
  input  logic [15:0] BASER_VAL,
  output logic        LD_BEN,
  output logic [2:0]  SR1_SEL,
  output logic        LD_PC,
  output logic [15:0] PC_NEXT,
  output logic        LD_R7,
  output logic [15:0] R7_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        TAKEN,
  output logic        ERR
);
  typedef enum logic [2:0] {IDLE, LDBEN, WAIT, EVAL, EXEC} state_t;
  localparam logic [1:0] CNT_INIT = 2'(BEN_WAIT > 1 ? BEN_WAIT - 2 : 0);
  state_t      state;
  logic [1:0]  cnt;
  logic [15:0] ir_q, pc_q, target;
  logic [3:0]  op;
  logic        take, jsr;
  // The base register is read combinationally, so its address tracks the captured IR
  assign SR1_SEL = ir_q[8:6];
  // Target and taken decision for the captured instruction, consumed in EVAL
  always_comb begin
    op     = ir_q[15:12];
    jsr    = op == 4'h4;
    target = op == 4'h0 ? pc_q + {{7{ir_q[8]}}, ir_q[8:0]} :
             jsr && ir_q[11] ? pc_q + {{5{ir_q[10]}}, ir_q[10:0]} : BASER_VAL;
    take   = op == 4'h0 ? BEN_IN : 1'b1;
  end
  // Control sequencer with registered strobes; PC_NEXT/R7_DATA hold between executions
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      PC_NEXT <= '0;
      R7_DATA <= '0;
      {LD_BEN, LD_PC, LD_R7, BUSY, DONE, TAKEN, ERR} <= '0;
    end else begin
      {LD_BEN, LD_PC, LD_R7, DONE, TAKEN, ERR} <= '0;
      case (state)
        IDLE: if (Start) begin
          ir_q <= IR;
          pc_q <= PC_IN;
          BUSY <= 1'b1;
          if (IR[15:12] == 4'h0) begin
            state  <= LDBEN;
            LD_BEN <= 1'b1;
          end else if (IR[15:12] == 4'hC || IR[15:12] == 4'h4) begin
            state <= EVAL;
          end else begin
            state <= EXEC;
            DONE  <= 1'b1;
            ERR   <= 1'b1;
          end
        end
        LDBEN: begin
          state <= BEN_WAIT == 1 ? EVAL : WAIT;
          cnt   <= CNT_INIT;
        end
        WAIT: begin
          state <= cnt == 2'd0 ? EVAL : WAIT;
          cnt   <= cnt == 2'd0 ? cnt : cnt - 2'd1;
        end
        EVAL: begin
          state   <= EXEC;
          DONE    <= 1'b1;
          TAKEN   <= take;
          LD_PC   <= take;
          LD_R7   <= jsr;
          PC_NEXT <= target;
          R7_DATA <= jsr ? pc_q : R7_DATA;
        end
        EXEC: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: scoreboard bench for branch_unit with BEN_WAIT=1 and BEN_WAIT=3 instances
module tb_branch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1, rst3, st1, st3, ben;
  logic [15:0] ir, pc, base;
  logic ld_ben1, ld_pc1, ld_r71, busy1, done1, taken1, err1;
  logic ld_ben3, ld_pc3, ld_r73, busy3, done3, taken3, err3;
  logic [2:0] sr1_1, sr1_3;
  logic [15:0] pcn1, r71, pcn3, r73;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [15:0] pc;
    logic [15:0] r7;
    logic ld_pc, ld_r7, taken, err;
    int lat;
  } res_t;
  res_t q[$];
  branch_unit #(.BEN_WAIT(1)) u1 (
    .Clk(clk), .Reset(rst1), .Start(st1), .IR(ir), .PC_IN(pc), .BEN_IN(ben), .BASER_VAL(base),
    .LD_BEN(ld_ben1), .SR1_SEL(sr1_1), .LD_PC(ld_pc1), .PC_NEXT(pcn1), .LD_R7(ld_r71),
    .R7_DATA(r71), .BUSY(busy1), .DONE(done1), .TAKEN(taken1), .ERR(err1));
  branch_unit #(.BEN_WAIT(3)) u3 (
    .Clk(clk), .Reset(rst3), .Start(st3), .IR(ir), .PC_IN(pc), .BEN_IN(ben), .BASER_VAL(base),
    .LD_BEN(ld_ben3), .SR1_SEL(sr1_3), .LD_PC(ld_pc3), .PC_NEXT(pcn3), .LD_R7(ld_r73),
    .R7_DATA(r73), .BUSY(busy3), .DONE(done3), .TAKEN(taken3), .ERR(err3));
  function automatic res_t predict(logic [15:0] i, logic [15:0] p, logic [15:0] b, logic bn, int bw);
    res_t e;
    e = '{default: 0};
    case (i[15:12])
      4'h0: begin e.pc = p + {{7{i[8]}}, i[8:0]}; e.ld_pc = bn; e.lat = 2 + bw; end
      4'hC: begin e.pc = b; e.ld_pc = 1'b1; e.lat = 2; end
      4'h4: begin
        e.pc = i[11] ? p + {{5{i[10]}}, i[10:0]} : b;
        e.ld_pc = 1'b1; e.ld_r7 = 1'b1; e.r7 = p; e.lat = 2;
      end
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    e.taken = e.ld_pc;
    return e;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] i, input logic [15:0] p, input logic [15:0] b, input logic bn);
    ir = i; pc = p; base = b; ben = bn; st1 = 1'b1;
    q.push_back(predict(i, p, b, bn, 1));
    tick();
    st1 = 1'b0;
  endtask
  task automatic collect(input int n0, output res_t o);
    o = '{default: 0};
    o.lat = -1;
    for (int n = n0; n <= n0 + 8; n++) begin
      if (done1) begin
        o.lat = n; o.pc = pcn1; o.r7 = r71; o.ld_pc = ld_pc1; o.ld_r7 = ld_r71;
        o.taken = taken1; o.err = err1;
        break;
      end
      tick();
    end
  endtask
  task automatic test_reset;
    rst1 = 1'b1; rst3 = 1'b1; ir = 16'h1000; pc = 16'h1111; st1 = 1'b1; st3 = 1'b1;
    tick(); tick();
    n_chk++;
    if ({ld_ben1, sr1_1, ld_pc1, pcn1, ld_r71, r71, busy1, done1, taken1, err1} !== '0) begin
      n_fail++; $display("FAIL reset_u1 got pc=%h r7=%h busy=%b err=%b exp all 0", pcn1, r71, busy1, err1);
    end
    n_chk++;
    if ({ld_ben3, sr1_3, ld_pc3, pcn3, ld_r73, r73, busy3, done3, taken3, err3} !== '0) begin
      n_fail++; $display("FAIL reset_u3 got pc=%h r7=%h busy=%b err=%b exp all 0", pcn3, r73, busy3, err3);
    end
    rst1 = 1'b0; rst3 = 1'b0; st1 = 1'b0; st3 = 1'b0;
    tick();
    n_chk++;
    if (busy1 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_priority got busy=%b err=%b exp 0 0", busy1, err1);
    end
  endtask
  task automatic test_ops;
    logic [15:0] ti[12], tp[12], tb[12];
    logic tn[12];
    logic [3:0] ops[3];
    res_t e, o;
    ops = '{4'h0, 4'hC, 4'h4};
    ti[0:5] = '{16'h0805, 16'h0FFF, 16'h4FFF, 16'h41C0, 16'hC080, 16'h0100};
    tp[0:5] = '{16'h3001, 16'h3001, 16'h0000, 16'h5000, 16'h7000, 16'hFFFF};
    tb[0:5] = '{16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'hBEEF, 16'h0000};
    tn[0:5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 6; k < 12; k++) begin
      ti[k] = 16'($urandom);
      ti[k][15:12] = ops[$urandom_range(0, 2)];
      tp[k] = 16'($urandom); tb[k] = 16'($urandom); tn[k] = 1'($urandom);
    end
    for (int k = 0; k < 12; k++) begin
      issue(ti[k], tp[k], tb[k], tn[k]);
      n_chk++;
      if (ld_ben1 !== (ti[k][15:12] == 4'h0) || busy1 !== 1'b1) begin
        n_fail++; $display("FAIL ops[%0d] cycle1 got ld_ben=%b busy=%b exp ld_ben=%b busy=1", k, ld_ben1, busy1, ti[k][15:12] == 4'h0);
      end
      if (ti[k][15:12] != 4'h0) begin
        n_chk++;
        if (sr1_1 !== ti[k][8:6]) begin
          n_fail++; $display("FAIL ops[%0d] sr1_sel got %0d exp %0d", k, sr1_1, ti[k][8:6]);
        end
      end
      collect(1, o);
      e = q.pop_front();
      n_chk++;
      if (o.lat !== e.lat || o.err !== e.err) begin
        n_fail++; $display("FAIL ops[%0d] latency/err got %0d/%b exp %0d/%b", k, o.lat, o.err, e.lat, e.err);
      end
      n_chk++;
      if (o.ld_pc !== e.ld_pc || o.taken !== e.taken || o.ld_r7 !== e.ld_r7) begin
        n_fail++; $display("FAIL ops[%0d] strobes got ld_pc=%b taken=%b ld_r7=%b exp %b %b %b", k, o.ld_pc, o.taken, o.ld_r7, e.ld_pc, e.taken, e.ld_r7);
      end
      n_chk++;
      if (o.pc !== e.pc) begin
        n_fail++; $display("FAIL ops[%0d] pc_next got %h exp %h", k, o.pc, e.pc);
      end
      if (e.ld_r7) begin
        n_chk++;
        if (o.r7 !== e.r7) begin
          n_fail++; $display("FAIL ops[%0d] r7_data got %h exp %h", k, o.r7, e.r7);
        end
      end
      tick();
      n_chk++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || ld_pc1 !== 1'b0 || pcn1 !== e.pc) begin
        n_fail++; $display("FAIL ops[%0d] after_exec got busy=%b done=%b ld_pc=%b pc=%h exp 0 0 0 %h", k, busy1, done1, ld_pc1, pcn1, e.pc);
      end
    end
  endtask
  task automatic test_illegal_busy;
    res_t e, o;
    issue(16'h1000, 16'h2222, 16'h3333, 1'b1);
    collect(1, o);
    e = q.pop_front();
    n_chk++;
    if (o.lat !== e.lat || o.err !== 1'b1 || o.ld_pc !== 1'b0 || o.ld_r7 !== 1'b0) begin
      n_fail++; $display("FAIL illegal got lat=%0d err=%b ld_pc=%b ld_r7=%b exp %0d 1 0 0", o.lat, o.err, o.ld_pc, o.ld_r7, e.lat);
    end
    tick();
    issue(16'h0805, 16'h3001, 16'h0000, 1'b1);
    ir = 16'h1000; pc = 16'hAAAA; st1 = 1'b1;
    tick();
    st1 = 1'b0;
    collect(2, o);
    e = q.pop_front();
    n_chk++;
    if (o.lat !== e.lat || o.err !== 1'b0 || o.pc !== 16'h3006 || o.ld_pc !== 1'b1) begin
      n_fail++; $display("FAIL busy_guard got lat=%0d err=%b pc=%h ld_pc=%b exp %0d 0 3006 1", o.lat, o.err, o.pc, o.ld_pc, e.lat);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      n_chk++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        n_fail++; $display("FAIL busy_guard_tail[%0d] got done=%b busy=%b exp 0 0", n, done1, busy1);
      end
    end
  endtask
  task automatic test_back_to_back;
    res_t e, o;
    issue(16'hC140, 16'h0000, 16'h4321, 1'b0);
    collect(1, o);
    e = q.pop_front();
    n_chk++;
    if (o.lat !== e.lat || o.pc !== e.pc) begin
      n_fail++; $display("FAIL b2b_first got lat=%0d pc=%h exp %0d %h", o.lat, o.pc, e.lat, e.pc);
    end
    ir = 16'hF000; st1 = 1'b1;
    tick();
    st1 = 1'b0;
    n_chk++;
    if (busy1 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_exec_start got busy=%b err=%b exp 0 0", busy1, err1);
    end
    issue(16'h4802, 16'h1000, 16'h0000, 1'b0);
    collect(1, o);
    e = q.pop_front();
    n_chk++;
    if (o.lat !== e.lat || o.pc !== e.pc || o.r7 !== e.r7 || o.ld_r7 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got lat=%0d pc=%h r7=%h ld_r7=%b exp %0d %h %h 1", o.lat, o.pc, o.r7, o.ld_r7, e.lat, e.pc, e.r7);
    end
    tick();
  endtask
  task automatic test_wait_reset;
    res_t e;
    int lat;
    ir = 16'h0E05; pc = 16'h3001; ben = 1'b1; st3 = 1'b1;
    tick();
    st3 = 1'b0;
    n_chk++;
    if (ld_ben3 !== 1'b1) begin
      n_fail++; $display("FAIL w3_ldben got %b exp 1", ld_ben3);
    end
    tick();
    n_chk++;
    if (busy3 !== 1'b1 || ld_ben3 !== 1'b0) begin
      n_fail++; $display("FAIL w3_wait got busy=%b ld_ben=%b exp 1 0", busy3, ld_ben3);
    end
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    n_chk++;
    if (busy3 !== 1'b0 || pcn3 !== 16'h0000) begin
      n_fail++; $display("FAIL w3_reset got busy=%b pc=%h exp 0 0000", busy3, pcn3);
    end
    for (int n = 0; n < 6; n++) begin
      tick();
      n_chk++;
      if (ld_pc3 !== 1'b0 || done3 !== 1'b0) begin
        n_fail++; $display("FAIL w3_cancel[%0d] got ld_pc=%b done=%b exp 0 0", n, ld_pc3, done3);
      end
    end
    e = predict(16'h0E05, 16'h3001, 16'h0000, 1'b1, 3);
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      if (done3) begin lat = n; break; end
      tick();
    end
    n_chk++;
    if (lat !== e.lat || pcn3 !== e.pc || ld_pc3 !== 1'b1) begin
      n_fail++; $display("FAIL w3_br got lat=%0d pc=%h ld_pc=%b exp %0d %h 1", lat, pcn3, ld_pc3, e.lat, e.pc);
    end
    tick();
  endtask
  initial begin
    rst1 = 1'b1; rst3 = 1'b1; st1 = 1'b0; st3 = 1'b0; ben = 1'b0;
    ir = '0; pc = '0; base = '0;
    test_reset();
    test_ops();
    test_illegal_busy();
    test_back_to_back();
    test_wait_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter BEN_WAIT, default 1, legal 1..4: cycles from the LD_BEN pulse to BEN_IN being sampled.
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  one-cycle request from control FSM to execute the instruction in IR.
REQ-005 SHALL have port IR  input  16  instruction register contents, sampled with Start.
REQ-006 SHALL have port PC_IN  input  16  already-incremented PC, sampled with Start.
REQ-007 SHALL have port BEN_IN  input  1  registered branch-enable from the condition-code/BEN block.
REQ-008 SHALL have port BASER_VAL  input  16  register-file read data for the base register.
REQ-009 SHALL have port LD_BEN  output  1  load strobe to the BEN register.
REQ-010 SHALL have port SR1_SEL  output  3  register-file read address; equals captured IR[8:6] in EVAL.
REQ-011 SHALL have port LD_PC / PC_NEXT  output  1 / 16  PC load strobe and target.
REQ-012 SHALL have port LD_R7 / R7_DATA  output  1 / 16  link-register write strobe and data.
REQ-013 SHALL have port BUSY, DONE, TAKEN, ERR  output  1 each  status; DONE, TAKEN and ERR are one-cycle pulses.

Function
REQ-014 SHALL implement states IDLE, LDBEN, WAIT, EVAL, EXEC.
REQ-015 IDLE: BUSY=0; Start=1 SHALL capture IR and PC_IN into internal registers and transition by opcode IR[15:12]: 0000 (BR) -> LDBEN; 1100 (JMP) or 0100 (JSR/JSRR) -> EVAL; any other -> EXEC with the error flag set.
REQ-016 LDBEN: LD_BEN=1 for exactly one cycle; next state is EVAL if BEN_WAIT=1, else WAIT.
REQ-017 WAIT: down-counter; after BEN_WAIT-1 cycles go to EVAL, so that EVAL is exactly BEN_WAIT cycles after LDBEN.
REQ-018 EVAL: drive SR1_SEL from captured IR[8:6]; register the target, the taken decision and the link value; next state is EXEC.
REQ-019 Target rules, all additions modulo 2^16:
- BR: PC_IN + SEXT(IR[8:0]); taken = BEN_IN sampled in EVAL.
- JMP: BASER_VAL; always taken.
- JSR (IR[11]=1): PC_IN + SEXT(IR[10:0]); always taken.
- JSRR (IR[11]=0): BASER_VAL; always taken.
REQ-020 JSR and JSRR SHALL register the captured PC_IN as the link value; the target SHALL be registered in EVAL, so JSRR R7 jumps to the old R7.
REQ-021 EXEC, one cycle, then IDLE: DONE=1; LD_PC=TAKEN; PC_NEXT=registered target; LD_R7=1 only for JSR/JSRR; R7_DATA=registered link value; ERR=1 with LD_PC=LD_R7=0 for illegal opcodes.
REQ-022 Latency from the Start edge to DONE SHALL be: BR 2+BEN_WAIT cycles; JMP/JSR/JSRR 2 cycles; illegal 1 cycle.
REQ-023 BUSY SHALL be 1 in every state except IDLE; Start while BUSY=1 SHALL be ignored and SHALL NOT alter captured IR or PC.
REQ-024 BR with IR[11:9]=000 relies on BEN_IN=0 and SHALL NOT be special-cased.
REQ-025 LD_PC, LD_R7, LD_BEN, DONE, TAKEN and ERR SHALL be 0 in every state other than the one assigning them.
REQ-026 PC_NEXT and R7_DATA SHALL hold their last registered value outside EXEC.

Reset
REQ-027 Reset=1 SHALL force IDLE on the next edge from any state, cancelling any pending PC or R7 load, and SHALL clear the wait counter and all captured and target registers to 0.
REQ-028 Reset SHALL take priority over Start on the same edge.
REQ-029 After reset, every output SHALL be 0, including PC_NEXT, R7_DATA and SR1_SEL.

Verification
REQ-030 BR taken: BEN_WAIT=1, IR=0x0805, PC_IN=0x3001, BEN_IN=1 -> LD_BEN at cycle 1; DONE, LD_PC, TAKEN at cycle 3; PC_NEXT=0x3006.
REQ-031 BR not taken: IR=0x0FFF, PC_IN=0x3001, BEN_IN=0 -> DONE at cycle 3, LD_PC=0, TAKEN=0.
REQ-032 JSR wrap-around: IR=0x4FFF, PC_IN=0x0000 -> cycle 2: PC_NEXT=0xFFFF, LD_PC=1, LD_R7=1, R7_DATA=0x0000.
REQ-033 JSRR R7: IR=0x41C0, BASER_VAL=0x1234, PC_IN=0x5000 -> SR1_SEL=7 in EVAL; PC_NEXT=0x1234, R7_DATA=0x5000.
REQ-034 BEN_WAIT=3 with Reset asserted in WAIT -> no LD_PC ever; IDLE and BUSY=0 the next cycle.
REQ-035 Illegal opcode and busy guard: IR=0x1000 -> ERR=1 and DONE=1 at cycle 1, no loads; a second Start during a BR in progress is ignored.
